alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency ALU.
// All outputs are registered; next values are built combinationally.
module alu_arbiter #(
  parameter int         ALU_LAT = 1,
  parameter logic [3:0] RST_OP  = 4'b1100,
  parameter logic [3:0] IDLE_OP = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [3:0]  op0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [3:0]  op1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] res,
  output logic [1:0]  err,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic [1:0]  alu_err
);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t      state, state_d;
  logic        ptr, ptr_d;
  logic        gnt, gnt_d;
  logic [3:0]  cnt, cnt_d;
  logic        pick;

  logic        ack0_d, ack1_d;
  logic        done0_d, done1_d;
  logic [31:0] res_d;
  logic [1:0]  err_d;
  logic        busy_d;
  logic [31:0] alu_a_d, alu_b_d;
  logic [3:0]  alu_op_d;

  // ptr holds the last granted requester; a tie goes to the other one
  always_comb begin
    pick = (req0 & req1) ? ~ptr : req1;
  end

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    gnt_d    = gnt;
    cnt_d    = cnt;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    res_d    = res;
    err_d    = err;
    busy_d   = busy;
    alu_a_d  = alu_a;
    alu_b_d  = alu_b;
    alu_op_d = alu_op;
    unique case (state)
      INIT: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        alu_op_d = IDLE_OP;
      end
      IDLE: begin
        if (req0 | req1) begin
          state_d  = ISSUE;
          ptr_d    = pick;
          gnt_d    = pick;
          cnt_d    = 4'(ALU_LAT - 1);
          busy_d   = 1'b1;
          ack0_d   = ~pick;
          ack1_d   = pick;
          alu_a_d  = pick ? a1 : a0;
          alu_b_d  = pick ? b1 : b0;
          alu_op_d = pick ? op1 : op0;
        end
      end
      ISSUE: begin
        if (cnt == 4'd0) begin
          state_d = DONE;
          res_d   = alu_res;
          err_d   = alu_err;
          done0_d = ~gnt;
          done1_d = gnt;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        alu_op_d = IDLE_OP;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      ptr    <= 1'b1;
      gnt    <= 1'b0;
      cnt    <= 4'd0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      res    <= 32'd0;
      err    <= 2'd0;
      busy   <= 1'b1;
      alu_a  <= 32'd0;
      alu_b  <= 32'd0;
      alu_op <= RST_OP;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      gnt    <= gnt_d;
      cnt    <= cnt_d;
      ack0   <= ack0_d;
      ack1   <= ack1_d;
      done0  <= done0_d;
      done1  <= done1_d;
      res    <= res_d;
      err    <= err_d;
      busy   <= busy_d;
      alu_a  <= alu_a_d;
      alu_b  <= alu_b_d;
      alu_op <= alu_op_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stub, directed scenarios and a
// randomized run against a round-robin reference model.
module tb_alu_arbiter;

  localparam int         LAT  = 1;
  localparam logic [3:0] ROP  = 4'b1100;
  localparam logic [3:0] IOP  = 4'b0000;
  localparam logic [3:0] EOP  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic        ack0, ack1, done0, done1, busy;
  logic [31:0] res, alu_a, alu_b;
  logic [1:0]  err;
  logic [3:0]  alu_op;
  logic [31:0] alu_res = '0;
  logic [1:0]  alu_err = '0;

  int checks = 0;
  int fails  = 0;
  bit ref_ptr;

  always #5 clk = ~clk;

  // ALU stub: registered on the falling edge so a result presented
  // at one rising edge is stable by the next one
  always @(negedge clk) begin
    alu_res <= alu_a + alu_b;
    alu_err <= (alu_op == EOP) ? 2'b01 : 2'b00;
  end

  alu_arbiter #(.ALU_LAT(LAT), .RST_OP(ROP), .IDLE_OP(IOP)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .res(res), .err(err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_err(alu_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    ref_ptr = 1'b1;
  endtask

  // Drives one request pattern from IDLE and reports what was seen.
  task automatic issue(
    input  bit r0, input bit r1,
    output logic [1:0] ack, output int done_at,
    output logic [1:0] dn, output logic [31:0] r,
    output logic [1:0] e, output logic late_ack,
    output logic idle_after);
    req0 = r0; req1 = r1;
    tick();
    ack = {ack0, ack1};
    req0 = 1'b0; req1 = 1'b0;
    done_at = -1; dn = 2'b00; r = '0; e = '0; late_ack = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done0 | done1) begin
        done_at = k; dn = {done0, done1};
        r = res; e = err; late_ack = ack0 | ack1;
        break;
      end
    end
    tick();
    idle_after = ~busy;
    for (int k = 0; k < 10 && busy; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || alu_op !== ROP) begin
      fails++;
      $display("FAIL reset_state busy=%b op=%b want 1/%b", busy, alu_op, ROP);
    end
    checks++;
    if ({ack0, ack1, done0, done1} !== 4'b0 || res !== 0 || err !== 0 ||
        alu_a !== 0 || alu_b !== 0) begin
      fail_line("reset_outs");
    end
    rst = 1'b0;
    checks++;
    if (alu_op !== ROP || busy !== 1'b1) begin
      fails++;
      $display("FAIL init_cycle op=%b busy=%b want %b/1", alu_op, busy, ROP);
    end
    tick();
    checks++;
    if (alu_op !== IOP || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_entry op=%b busy=%b want %b/0", alu_op, busy, IOP);
    end
    ref_ptr = 1'b1;
  endtask

  task automatic fail_line(input string name);
    fails++;
    $display("FAIL %s ack=%b%b done=%b%b res=%0d err=%b a=%0d b=%0d want zeros",
             name, ack0, ack1, done0, done1, res, err, alu_a, alu_b);
  endtask

  task automatic test_single();
    a0 = 32'd3000; b0 = 32'd20617524; op0 = 4'b0011;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    checks++;
    if ({ack0, ack1} !== 2'b10 || alu_a !== 32'd3000 || alu_op !== 4'b0011) begin
      fails++;
      $display("FAIL single_ack ack=%b%b a=%0d op=%b want 10/3000/0011",
               ack0, ack1, alu_a, alu_op);
    end
    tick();
    checks++;
    if ({done0, done1} !== 2'b10 || res !== 32'd20620524 || err !== 2'b00) begin
      fails++;
      $display("FAIL single_done done=%b%b res=%0d err=%b want 10/20620524/00",
               done0, done1, res, err);
    end
    tick();
    checks++;
    if ({done0, done1} !== 2'b00 || busy !== 1'b0 || alu_op !== IOP) begin
      fails++;
      $display("FAIL single_idle done=%b%b busy=%b op=%b want 00/0/%b",
               done0, done1, busy, alu_op, IOP);
    end
    ref_ptr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int per = LAT + 2;
    int ph, g;
    logic [1:0] xa, xd;
    logic [31:0] xr;
    apply_reset();
    a0 = $urandom; b0 = $urandom; op0 = 4'b0011;
    a1 = $urandom; b1 = $urandom; op1 = 4'b0001;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      ph = (c - 1) % per;
      g  = ((c - 1) / per) % 2;
      xa = (ph == 0)   ? ((g == 1) ? 2'b01 : 2'b10) : 2'b00;
      xd = (ph == LAT) ? ((g == 1) ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if ({ack0, ack1} !== xa) begin
        fails++;
        $display("FAIL rr_ack c=%0d got %b%b want %b", c, ack0, ack1, xa);
      end
      checks++;
      if ({done0, done1} !== xd) begin
        fails++;
        $display("FAIL rr_done c=%0d got %b%b want %b", c, done0, done1, xd);
      end
      if (ph == LAT) begin
        xr = (g == 1) ? a1 + b1 : a0 + b0;
        checks++;
        if (res !== xr) begin
          fails++;
          $display("FAIL rr_res c=%0d got %0d want %0d", c, res, xr);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    ref_ptr = 1'b1;
  endtask

  task automatic test_err();
    logic [1:0] ack, dn, e;
    logic [31:0] r;
    logic la, idl;
    int dat;
    a1 = 32'd7; b1 = 32'd9; op1 = EOP;
    issue(1'b0, 1'b1, ack, dat, dn, r, e, la, idl);
    ref_ptr = 1'b1;
    checks++;
    if (ack !== 2'b01 || dn !== 2'b01 || dat != LAT || e !== 2'b01 || r !== 32'd16) begin
      fails++;
      $display("FAIL err_op ack=%b done=%b at=%0d err=%b res=%0d want 01/01/%0d/01/16",
               ack, dn, dat, e, r, LAT);
    end
    a0 = 32'd100; b0 = 32'd23; op0 = 4'b0011;
    issue(1'b1, 1'b0, ack, dat, dn, r, e, la, idl);
    ref_ptr = 1'b0;
    checks++;
    if (ack !== 2'b10 || dn !== 2'b10 || dat != LAT || e !== 2'b00 || r !== 32'd123) begin
      fails++;
      $display("FAIL err_after ack=%b done=%b at=%0d err=%b res=%0d want 10/10/%0d/00/123",
               ack, dn, dat, e, r, LAT);
    end
  endtask

  task automatic test_rst_mid();
    logic [1:0] ack, dn, e;
    logic [31:0] r;
    logic la, idl;
    int dat;
    a0 = 32'd55; b0 = 32'd45; op0 = 4'b0011;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({done0, done1} !== 2'b00 || busy !== 1'b1 || alu_op !== ROP || res !== 0) begin
      fails++;
      $display("FAIL rst_mid done=%b%b busy=%b op=%b res=%0d want 00/1/%b/0",
               done0, done1, busy, alu_op, res, ROP);
    end
    tick();
    checks++;
    if ({done0, done1} !== 2'b00 || busy !== 1'b0 || alu_op !== IOP) begin
      fails++;
      $display("FAIL rst_idle done=%b%b busy=%b op=%b want 00/0/%b",
               done0, done1, busy, alu_op, IOP);
    end
    ref_ptr = 1'b1;
    issue(1'b1, 1'b0, ack, dat, dn, r, e, la, idl);
    ref_ptr = 1'b0;
    checks++;
    if (ack !== 2'b10 || dn !== 2'b10 || r !== 32'd100 || e !== 2'b00) begin
      fails++;
      $display("FAIL rst_reissue ack=%b done=%b res=%0d err=%b want 10/10/100/00",
               ack, dn, r, e);
    end
  endtask

  task automatic test_hold_operands();
    logic [31:0] xa, xb;
    xa = $urandom; xb = $urandom;
    a0 = xa; b0 = xb; op0 = 4'b0011;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    a0 = ~xa; b0 = xb + 32'd5; op0 = EOP;
    tick();
    checks++;
    if (done0 !== 1'b1 || res !== xa + xb || err !== 2'b00) begin
      fails++;
      $display("FAIL hold_ops done0=%b res=%0d err=%b want 1/%0d/00",
               done0, res, err, xa + xb);
    end
    tick();
    ref_ptr = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] ack, dn, e, xg;
    logic [31:0] r, xr;
    logic [1:0] xe;
    logic la, idl;
    int dat, sel;
    bit r0, r1, g;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      r0 = sel[0]; r1 = sel[1];
      a0 = $urandom; b0 = $urandom; op0 = 4'($urandom_range(0, 15));
      a1 = $urandom; b1 = $urandom; op1 = 4'($urandom_range(0, 15));
      g  = (r0 && r1) ? !ref_ptr : r1;
      xg = g ? 2'b01 : 2'b10;
      xr = g ? a1 + b1 : a0 + b0;
      xe = ((g ? op1 : op0) == EOP) ? 2'b01 : 2'b00;
      issue(r0, r1, ack, dat, dn, r, e, la, idl);
      ref_ptr = g;
      checks++;
      if (ack !== xg || dn !== xg || dat != LAT) begin
        fails++;
        $display("FAIL rand_grant i=%0d ack=%b done=%b at=%0d want %b/%b/%0d",
                 i, ack, dn, dat, xg, xg, LAT);
      end
      checks++;
      if (r !== xr || e !== xe || la !== 1'b0 || idl !== 1'b1) begin
        fails++;
        $display("FAIL rand_res i=%0d res=%0d err=%b lateack=%b idle=%b want %0d/%b/0/1",
                 i, r, e, la, idl, xr, xe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_err();
    test_rst_mid();
    test_hold_operands();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
